id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode->execute pipeline register feeding the ALU (OpCode/funct/Rs/Rt/Pc/Imm).
//  Applies operand forwarding at capture, detects load-use hazards (bubble + decode
//  hold), and supports downstream stall and branch flush. Sole source of ALU inputs.
// PARAMETERS
//  DW  16  datapath width (Rs, Rt, Pc, forwarded data)
//  RW  3   register index width (8 GPRs, r0 is an ordinary register)
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  id_valid     in   1   decode presents an instruction
//  id_opcode    in   5   decoded OpCode
//  id_funct     in   2   decoded funct
//  id_rs_val    in   DW  regfile read A
//  id_rt_val    in   DW  regfile read B
//  id_pc        in   DW  PC+2 of instruction
//  id_imm       in   8   raw immediate field
//  id_rs_idx    in   RW  source A index;  id_rs_used in 1  source A is read
//  id_rt_idx    in   RW  source B index;  id_rt_used in 1  source B is read
//  id_wr_idx    in   RW  dest index;      id_wr_en   in 1  writes a GPR
//  id_is_load   in   1   instruction is LD
//  ex_res       in   DW  ALU result of instruction currently held here
//  mem_wr_en    in   1   MEM-stage instruction writes a GPR
//  mem_wr_idx   in   RW  MEM-stage dest index
//  mem_data     in   DW  MEM-stage writeback value (ALU result or load data)
//  ex_stall     in   1   downstream freeze (whole pipe beyond decode holds)
//  flush        in   1   branch/jump redirect; kill instruction being captured
//  id_ready     out  1   decode may advance this cycle
//  ex_valid     out  1   held instruction is real (0 = bubble)
//  ex_opcode/ex_funct/ex_rs/ex_rt/ex_pc/ex_imm  out 5/2/DW/DW/DW/8  ALU inputs
//  ex_wr_idx    out  RW  ex_wr_en out 1  ex_is_load out 1  carried to MEM
// BEHAVIOUR
//  Reset: all outputs 0, ex_valid=0; id_ready=1 once rst_n deasserts.
//  Fwd A hit: ex_valid & ex_wr_en & ~ex_is_load & ex_wr_idx==src -> ex_res.
//  Fwd B hit: mem_wr_en & mem_wr_idx==src -> mem_data.
//  Priority per operand: A > B > id_*_val. WB needs no forwarding (regfile write-through).
//  load_use = id_valid & ex_valid & ex_is_load & ex_wr_en &
//             ((id_rs_used & id_rs_idx==ex_wr_idx) | (id_rt_used & id_rt_idx==ex_wr_idx)).
//  id_ready = ~ex_stall & ~load_use (combinational).
//  Next-state, priority high->low at each rising edge:
//   1 flush: ex_valid<=0, ex_wr_en<=0, ex_is_load<=0; data fields don't-care.
//   2 ex_stall: hold every register unchanged (including bubbles).
//   3 load_use: insert bubble (ex_valid/ex_wr_en/ex_is_load<=0); decode holds.
//   4 else: capture id_* with forwarded operands; ex_valid<=id_valid;
//     ex_wr_en/ex_is_load gated by id_valid.
//  Latency: 1 cycle decode->ALU inputs; load-use costs exactly 1 bubble.
//  Unused operands (used=0) never create hazards; value still captured as-is.
//  Bubble never forwards or causes load_use (gated by ex_valid).
//  Reset mid-stall or mid-bubble: immediately returns to reset state.
//  flush & ex_stall together: flush wins (kill is never lost).
// STRUCTURE
//  Package wisc_pkg: OpCode constants (OP_LD=5'b10001, OP_ST, ...), DW/RW localparams.
//  Sub-module fwd_mux: one instance per operand (idx, used, regval, A/B sources -> value).
//  All state in one always block with async-reset branch; hazard logic combinational.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> ex_valid=0, ex_rs=0, id_ready=1 after release.
//  2 ADDI r2 then ADD r3,r2,r1 back-to-back, ex_res=16'h0042 -> ex_rs=16'h0042 next cycle.
//  3 Dual hit: r4 in EX (ex_res=16'h1111) and MEM (mem_data=16'h2222) -> ex_rs=16'h1111.
//  4 LD r5 then ADD r6,r5,r5 -> id_ready=0 one cycle, one bubble,
//    then ex_rs=ex_rt=mem_data=16'hBEEF.
//  5 ex_stall=1 for 3 cycles with new id_* changing -> ex_* outputs constant,
//    id_ready=0; resume captures latest id_*.
//  6 flush=1 with ex_stall=1 -> next cycle ex_valid=0; a following LD hazard does not trigger.

Source files
------------

// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared widths and opcode constants for the decode/execute boundary
package wisc_pkg;

  localparam int DW     = 16;
  localparam int RW     = 3;
  localparam int OP_W   = 5;
  localparam int FUNCT_W = 2;
  localparam int IMM_W  = 8;

  localparam logic [OP_W-1:0] OP_HALT = 5'b00000;
  localparam logic [OP_W-1:0] OP_J    = 5'b00100;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01000;
  localparam logic [OP_W-1:0] OP_BEQZ = 5'b01100;
  localparam logic [OP_W-1:0] OP_ST   = 5'b10000;
  localparam logic [OP_W-1:0] OP_LD   = 5'b10001;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b11011;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - per-operand forwarding select: EX result over MEM writeback over regfile
module fwd_mux #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic [RW-1:0] src_idx,
  input  logic          src_used,
  input  logic [DW-1:0] reg_val,
  input  logic          a_en,
  input  logic [RW-1:0] a_idx,
  input  logic [DW-1:0] a_data,
  input  logic          b_en,
  input  logic [RW-1:0] b_idx,
  input  logic [DW-1:0] b_data,
  output logic [DW-1:0] value
);

  // An operand that is not read keeps its raw regfile value.
  always_comb begin
    value = reg_val;
    if (src_used) begin
      if (a_en && (a_idx == src_idx)) begin
        value = a_data;
      end else if (b_en && (b_idx == src_idx)) begin
        value = b_data;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with capture-time forwarding and load-use bubbles
module id_ex_stage #(
  parameter int DW = wisc_pkg::DW,
  parameter int RW = wisc_pkg::RW
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [wisc_pkg::OP_W-1:0]     id_opcode,
  input  logic [wisc_pkg::FUNCT_W-1:0]  id_funct,
  input  logic [DW-1:0]                 id_rs_val,
  input  logic [DW-1:0]                 id_rt_val,
  input  logic [DW-1:0]                 id_pc,
  input  logic [wisc_pkg::IMM_W-1:0]    id_imm,
  input  logic [RW-1:0]                 id_rs_idx,
  input  logic                          id_rs_used,
  input  logic [RW-1:0]                 id_rt_idx,
  input  logic                          id_rt_used,
  input  logic [RW-1:0]                 id_wr_idx,
  input  logic                          id_wr_en,
  input  logic                          id_is_load,
  input  logic [DW-1:0]                 ex_res,
  input  logic                          mem_wr_en,
  input  logic [RW-1:0]                 mem_wr_idx,
  input  logic [DW-1:0]                 mem_data,
  input  logic                          ex_stall,
  input  logic                          flush,
  output logic                          id_ready,
  output logic                          ex_valid,
  output logic [wisc_pkg::OP_W-1:0]     ex_opcode,
  output logic [wisc_pkg::FUNCT_W-1:0]  ex_funct,
  output logic [DW-1:0]                 ex_rs,
  output logic [DW-1:0]                 ex_rt,
  output logic [DW-1:0]                 ex_pc,
  output logic [wisc_pkg::IMM_W-1:0]    ex_imm,
  output logic [RW-1:0]                 ex_wr_idx,
  output logic                          ex_wr_en,
  output logic                          ex_is_load
);

  logic          ex_fwd_en;
  logic          rs_hits_load;
  logic          rt_hits_load;
  logic          load_use;
  logic [DW-1:0] rs_fwd;
  logic [DW-1:0] rt_fwd;

  // A load's EX result is only an address, so it must never be forwarded.
  assign ex_fwd_en = ex_valid & ex_wr_en & ~ex_is_load;

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .src_idx  (id_rs_idx),
    .src_used (id_rs_used),
    .reg_val  (id_rs_val),
    .a_en     (ex_fwd_en),
    .a_idx    (ex_wr_idx),
    .a_data   (ex_res),
    .b_en     (mem_wr_en),
    .b_idx    (mem_wr_idx),
    .b_data   (mem_data),
    .value    (rs_fwd)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .src_idx  (id_rt_idx),
    .src_used (id_rt_used),
    .reg_val  (id_rt_val),
    .a_en     (ex_fwd_en),
    .a_idx    (ex_wr_idx),
    .a_data   (ex_res),
    .b_en     (mem_wr_en),
    .b_idx    (mem_wr_idx),
    .b_data   (mem_data),
    .value    (rt_fwd)
  );

  assign rs_hits_load = id_rs_used & (id_rs_idx == ex_wr_idx);
  assign rt_hits_load = id_rt_used & (id_rt_idx == ex_wr_idx);
  assign load_use     = id_valid & ex_valid & ex_is_load & ex_wr_en & (rs_hits_load | rt_hits_load);
  assign id_ready     = ~ex_stall & ~load_use;

  // Bubbles only clear the control bits; data fields are don't-care while ex_valid=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_opcode  <= '0;
      ex_funct   <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_pc      <= '0;
      ex_imm     <= '0;
      ex_wr_idx  <= '0;
      ex_wr_en   <= 1'b0;
      ex_is_load <= 1'b0;
    end else if (flush) begin
      ex_valid   <= 1'b0;
      ex_wr_en   <= 1'b0;
      ex_is_load <= 1'b0;
    end else if (!ex_stall) begin
      if (load_use) begin
        ex_valid   <= 1'b0;
        ex_wr_en   <= 1'b0;
        ex_is_load <= 1'b0;
      end else begin
        ex_valid   <= id_valid;
        ex_opcode  <= id_opcode;
        ex_funct   <= id_funct;
        ex_rs      <= rs_fwd;
        ex_rt      <= rt_fwd;
        ex_pc      <= id_pc;
        ex_imm     <= id_imm;
        ex_wr_idx  <= id_wr_idx;
        ex_wr_en   <= id_valid & id_wr_en;
        ex_is_load <= id_valid & id_is_load;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed and randomized checks of id_ex_stage against a reference model
module tb_id_ex_stage;
  import wisc_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_opcode;
  logic [1:0]  id_funct;
  logic [15:0] id_rs_val, id_rt_val, id_pc;
  logic [7:0]  id_imm;
  logic [2:0]  id_rs_idx, id_rt_idx, id_wr_idx;
  logic        id_rs_used, id_rt_used, id_wr_en, id_is_load;
  logic [15:0] ex_res;
  logic        mem_wr_en;
  logic [2:0]  mem_wr_idx;
  logic [15:0] mem_data;
  logic        ex_stall, flush;
  logic        id_ready, ex_valid;
  logic [4:0]  ex_opcode;
  logic [1:0]  ex_funct;
  logic [15:0] ex_rs, ex_rt, ex_pc;
  logic [7:0]  ex_imm;
  logic [2:0]  ex_wr_idx;
  logic        ex_wr_en, ex_is_load;

  int checks = 0;
  int errors = 0;

  // Reference model of the instruction currently sitting at the ALU inputs.
  logic        m_valid, m_wr_en, m_is_load;
  logic [4:0]  m_opcode;
  logic [1:0]  m_funct;
  logic [15:0] m_rs, m_rt, m_pc;
  logic [7:0]  m_imm;
  logic [2:0]  m_wr_idx;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs_idx(id_rs_idx), .id_rs_used(id_rs_used), .id_rt_idx(id_rt_idx), .id_rt_used(id_rt_used),
    .id_wr_idx(id_wr_idx), .id_wr_en(id_wr_en), .id_is_load(id_is_load), .ex_res(ex_res),
    .mem_wr_en(mem_wr_en), .mem_wr_idx(mem_wr_idx), .mem_data(mem_data), .ex_stall(ex_stall),
    .flush(flush), .id_ready(id_ready), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_funct(ex_funct), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_wr_idx(ex_wr_idx), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_valid = 0; m_wr_en = 0; m_is_load = 0; m_opcode = 0; m_funct = 0;
    m_rs = 0; m_rt = 0; m_pc = 0; m_imm = 0; m_wr_idx = 0;
  endtask

  // True when the instruction in EX is a real, GPR-writing load targeting a register decode reads.
  function automatic logic exp_load_use();
    logic waits_on_load;
    waits_on_load = (id_rs_used && id_rs_idx == m_wr_idx) || (id_rt_used && id_rt_idx == m_wr_idx);
    return id_valid && m_valid && m_is_load && m_wr_en && waits_on_load;
  endfunction

  // Newest producer wins: EX (if a real non-load writer), then MEM, then the regfile read.
  function automatic logic [15:0] exp_operand(input logic [2:0] idx, input logic used, input logic [15:0] regval);
    if (!used) return regval;
    if (m_valid && m_wr_en && !m_is_load && m_wr_idx == idx) return ex_res;
    if (mem_wr_en && mem_wr_idx == idx) return mem_data;
    return regval;
  endfunction

  task automatic tick();
    logic        kill;
    logic        take;
    logic [15:0] n_rs, n_rt;
    kill = flush || (!ex_stall && exp_load_use());
    take = !flush && !ex_stall && !exp_load_use();
    n_rs = exp_operand(id_rs_idx, id_rs_used, id_rs_val);
    n_rt = exp_operand(id_rt_idx, id_rt_used, id_rt_val);
    @(posedge clk);
    if (kill) begin
      m_valid = 0; m_wr_en = 0; m_is_load = 0;
    end else if (take) begin
      m_valid = id_valid; m_opcode = id_opcode; m_funct = id_funct;
      m_rs = n_rs; m_rt = n_rt; m_pc = id_pc; m_imm = id_imm; m_wr_idx = id_wr_idx;
      m_wr_en = id_valid && id_wr_en; m_is_load = id_valid && id_is_load;
    end
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_opcode = 0; id_funct = 0; id_rs_val = 0; id_rt_val = 0; id_pc = 0; id_imm = 0;
    id_rs_idx = 0; id_rs_used = 0; id_rt_idx = 0; id_rt_used = 0; id_wr_idx = 0; id_wr_en = 0;
    id_is_load = 0; ex_res = 0; mem_wr_en = 0; mem_wr_idx = 0; mem_data = 0; ex_stall = 0; flush = 0;
  endtask

  task automatic set_instr(input logic [4:0] op, input logic [2:0] rs, input logic rs_u, input logic [2:0] rt,
                           input logic rt_u, input logic [2:0] wr, input logic wr_e, input logic ld,
                           input logic [15:0] rs_v, input logic [15:0] rt_v, input logic [15:0] pc);
    id_valid = 1; id_opcode = op; id_funct = 2'b01; id_imm = 8'h05;
    id_rs_idx = rs; id_rs_used = rs_u; id_rt_idx = rt; id_rt_used = rt_u;
    id_wr_idx = wr; id_wr_en = wr_e; id_is_load = ld;
    id_rs_val = rs_v; id_rt_val = rt_v; id_pc = pc;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", ex_valid); end
    checks++; if (ex_opcode !== 5'd0) begin errors++; $display("FAIL reset_opcode got %h want 0", ex_opcode); end
    rst_n = 1;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", id_ready); end
    // Real instruction in flight, then reset asserted while the pipe is stalled.
    set_instr(OP_ADDI, 3'd1, 1, 3'd0, 0, 3'd2, 1, 0, 16'h1234, 16'h0, 16'h0040);
    #1; tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL reset_prefill got %0b want 1", ex_valid); end
    ex_stall = 1;
    #2 rst_n = 0;
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_async_valid got %0b want 0", ex_valid); end
    checks++; if (ex_rs !== 16'h0) begin errors++; $display("FAIL reset_async_rs got %h want 0000", ex_rs); end
    model_reset();
    idle();
    #1 rst_n = 1;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %0b want 1", id_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_fwd_ex();
    idle();
    set_instr(OP_ADDI, 3'd1, 1, 3'd0, 0, 3'd2, 1, 0, 16'h0040, 16'h0, 16'h0010);
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL fwd_ex_ready got %0b want 1", id_ready); end
    tick();
    checks++; if (ex_opcode !== OP_ADDI) begin errors++; $display("FAIL fwd_ex_op got %h want %h", ex_opcode, OP_ADDI); end
    set_instr(OP_ADD, 3'd2, 1, 3'd1, 1, 3'd3, 1, 0, 16'h0005, 16'h0002, 16'h0012);
    ex_res = 16'h0042;
    #1; tick();
    checks++; if (ex_rs !== 16'h0042) begin errors++; $display("FAIL fwd_ex_rs got %h want 0042", ex_rs); end
    checks++; if (ex_rt !== 16'h0002) begin errors++; $display("FAIL fwd_ex_rt got %h want 0002", ex_rt); end
    checks++; if (ex_wr_idx !== 3'd3) begin errors++; $display("FAIL fwd_ex_wr_idx got %0d want 3", ex_wr_idx); end
  endtask

  task automatic test_dual_hit();
    idle();
    set_instr(OP_ADDI, 3'd0, 1, 3'd0, 0, 3'd4, 1, 0, 16'h0001, 16'h0, 16'h0020);
    #1; tick();
    set_instr(OP_ADD, 3'd4, 1, 3'd4, 1, 3'd7, 1, 0, 16'h0BAD, 16'h0BAD, 16'h0022);
    ex_res = 16'h1111; mem_wr_en = 1; mem_wr_idx = 3'd4; mem_data = 16'h2222;
    #1; tick();
    checks++; if (ex_rs !== 16'h1111) begin errors++; $display("FAIL dual_hit_rs got %h want 1111", ex_rs); end
    checks++; if (ex_rt !== 16'h1111) begin errors++; $display("FAIL dual_hit_rt got %h want 1111", ex_rt); end
    // Now r7 is in EX and r4 only in MEM: each operand picks its own source.
    set_instr(OP_ADD, 3'd4, 1, 3'd7, 1, 3'd1, 1, 0, 16'h0BAD, 16'h0BAD, 16'h0024);
    ex_res = 16'h3333;
    #1; tick();
    checks++; if (ex_rs !== 16'h2222) begin errors++; $display("FAIL mem_only_rs got %h want 2222", ex_rs); end
    checks++; if (ex_rt !== 16'h3333) begin errors++; $display("FAIL ex_only_rt got %h want 3333", ex_rt); end
  endtask

  task automatic test_load_use();
    idle();
    set_instr(OP_LD, 3'd1, 1, 3'd0, 0, 3'd5, 1, 1, 16'h0100, 16'h0, 16'h0030);
    #1; tick();
    set_instr(OP_ADD, 3'd5, 1, 3'd5, 1, 3'd6, 1, 0, 16'h0000, 16'h0000, 16'h0032);
    ex_res = 16'hDEAD;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL load_use_ready got %0b want 0", id_ready); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL load_use_bubble got %0b want 0", ex_valid); end
    checks++; if (ex_wr_en !== 1'b0) begin errors++; $display("FAIL load_use_bubble_wr got %0b want 0", ex_wr_en); end
    mem_wr_en = 1; mem_wr_idx = 3'd5; mem_data = 16'hBEEF;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL load_use_release got %0b want 1", id_ready); end
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL load_use_valid got %0b want 1", ex_valid); end
    checks++; if (ex_rs !== 16'hBEEF) begin errors++; $display("FAIL load_use_rs got %h want beef", ex_rs); end
    checks++; if (ex_rt !== 16'hBEEF) begin errors++; $display("FAIL load_use_rt got %h want beef", ex_rt); end
    idle();
  endtask

  task automatic test_stall();
    logic [15:0] last_rs;
    idle();
    set_instr(OP_ADDI, 3'd2, 1, 3'd0, 0, 3'd1, 1, 0, 16'h0AAA, 16'h0, 16'h0100);
    #1; tick();
    ex_stall = 1;
    last_rs = 0;
    for (int i = 0; i < 3; i++) begin
      last_rs = 16'($urandom);
      set_instr(OP_ADD, 3'd2, 1, 3'd3, 0, 3'd6, 1, 0, last_rs, 16'h0, 16'h0200 + 16'(i * 2));
      ex_res = 16'($urandom);
      #1;
      checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL stall_ready cyc %0d got %0b want 0", i, id_ready); end
      tick();
      checks++; if (ex_pc !== 16'h0100) begin errors++; $display("FAIL stall_pc cyc %0d got %h want 0100", i, ex_pc); end
      checks++; if (ex_rs !== 16'h0AAA) begin errors++; $display("FAIL stall_rs cyc %0d got %h want 0aaa", i, ex_rs); end
    end
    ex_stall = 0;
    #1; tick();
    checks++; if (ex_pc !== 16'h0204) begin errors++; $display("FAIL stall_resume_pc got %h want 0204", ex_pc); end
    checks++; if (ex_rs !== last_rs) begin errors++; $display("FAIL stall_resume_rs got %h want %h", ex_rs, last_rs); end
  endtask

  task automatic test_flush();
    idle();
    set_instr(OP_LD, 3'd1, 1, 3'd0, 0, 3'd5, 1, 1, 16'h0100, 16'h0, 16'h0300);
    #1; tick();
    set_instr(OP_ADD, 3'd5, 1, 3'd0, 0, 3'd6, 1, 0, 16'h0077, 16'h0, 16'h0302);
    flush = 1; ex_stall = 1;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL flush_stall_ready got %0b want 0", id_ready); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", ex_valid); end
    checks++; if (ex_is_load !== 1'b0) begin errors++; $display("FAIL flush_is_load got %0b want 0", ex_is_load); end
    flush = 0; ex_stall = 0;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL flush_no_hazard got %0b want 1", id_ready); end
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL flush_next_valid got %0b want 1", ex_valid); end
    checks++; if (ex_rs !== 16'h0077) begin errors++; $display("FAIL flush_next_rs got %h want 0077", ex_rs); end
    idle();
  endtask

  task automatic test_random();
    logic want_ready;
    for (int n = 0; n < 400; n++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_opcode = 5'($urandom); id_funct = 2'($urandom); id_imm = 8'($urandom);
      id_rs_val = 16'($urandom); id_rt_val = 16'($urandom); id_pc = 16'($urandom);
      id_rs_idx = 3'($urandom); id_rt_idx = 3'($urandom); id_wr_idx = 3'($urandom);
      id_rs_used = 1'($urandom); id_rt_used = 1'($urandom); id_wr_en = 1'($urandom);
      id_is_load = ($urandom_range(0, 2) == 0);
      ex_res = 16'($urandom); mem_data = 16'($urandom);
      mem_wr_en = 1'($urandom); mem_wr_idx = 3'($urandom);
      ex_stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 15) == 0);
      #1;
      want_ready = !ex_stall && !exp_load_use();
      checks++; if (id_ready !== want_ready) begin errors++; $display("FAIL rnd_ready cyc %0d got %0b want %0b", n, id_ready, want_ready); end
      tick();
      checks++; if (ex_valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", n, ex_valid, m_valid); end
      checks++; if (ex_wr_en !== m_wr_en) begin errors++; $display("FAIL rnd_wr_en cyc %0d got %0b want %0b", n, ex_wr_en, m_wr_en); end
      checks++; if (ex_is_load !== m_is_load) begin errors++; $display("FAIL rnd_is_load cyc %0d got %0b want %0b", n, ex_is_load, m_is_load); end
      if (m_valid) begin
        checks++; if (ex_rs !== m_rs) begin errors++; $display("FAIL rnd_rs cyc %0d got %h want %h", n, ex_rs, m_rs); end
        checks++; if (ex_rt !== m_rt) begin errors++; $display("FAIL rnd_rt cyc %0d got %h want %h", n, ex_rt, m_rt); end
        checks++; if ({ex_opcode, ex_funct, ex_imm} !== {m_opcode, m_funct, m_imm}) begin
          errors++; $display("FAIL rnd_op cyc %0d got %h want %h", n, {ex_opcode, ex_funct, ex_imm}, {m_opcode, m_funct, m_imm});
        end
        checks++; if ({ex_pc, ex_wr_idx} !== {m_pc, m_wr_idx}) begin
          errors++; $display("FAIL rnd_pc_wr cyc %0d got %h want %h", n, {ex_pc, ex_wr_idx}, {m_pc, m_wr_idx});
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fwd_ex();
    test_dual_hit();
    test_load_use();
    test_stall();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
